// File: rtl/clk_div_bank.sv
// Bank of independent run-time-programmable clock dividers with tick strobes.
// Each channel double-buffers its divide/high-time and swaps at its own period boundary.

module clk_div_ch #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SYNC,
    input  logic             we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);
    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] cnt, div, high, sdiv, shigh;
    logic [WIDTH-1:0] cnt_n, div_n, high_n;
    logic             pending, tick_n, clk_n, apply, hold, live;

    always_comb begin
        cnt_n  = cnt;
        div_n  = div;
        high_n = high;
        tick_n = 1'b0;
        apply  = 1'b0;
        hold   = 1'b0;
        live   = 1'b1;
        if (SYNC) begin
            cnt_n = '0;
            apply = pending;
        end else if (div < TWO) begin
            // stopped channel: parked at zero, but still picks up a new config
            cnt_n = '0;
            apply = pending;
            live  = 1'b0;
        end else if (!EN) begin
            hold = 1'b1;
        end else if (cnt == div - WIDTH'(1)) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            apply  = pending;
        end else begin
            cnt_n = cnt + WIDTH'(1);
        end
        if (apply) begin
            div_n  = sdiv;
            high_n = shigh;
        end
        clk_n = hold ? clk_out : (live && (div_n >= TWO) && (cnt_n < high_n));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            div     <= DEF_D;
            high    <= DEF_H;
            sdiv    <= DEF_D;
            shigh   <= DEF_H;
            pending <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div     <= div_n;
            high    <= high_n;
            tick    <= tick_n;
            clk_out <= clk_n;
            // a write landing on the swap edge stays queued for the next boundary
            if (we) begin
                sdiv    <= cfg_div;
                shigh   <= cfg_high;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign pend = pending;
endmodule

module clk_div_bank #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SYNC,
    input  logic             CFG_WE,
    input  logic [CH_W-1:0]  CFG_CH,
    input  logic [WIDTH-1:0] CFG_DIV,
    input  logic [WIDTH-1:0] CFG_HIGH,
    output logic [N_CH-1:0]  TICK,
    output logic [N_CH-1:0]  CLK_OUT,
    output logic [N_CH-1:0]  PEND
);
    logic [N_CH-1:0] we;

    // out-of-range channel numbers match no index and are dropped
    always_comb begin
        we = '0;
        for (int i = 0; i < N_CH; i++)
            we[i] = CFG_WE && (CFG_CH == CH_W'(i));
    end

    clk_div_ch #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch [N_CH-1:0] (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .SYNC    (SYNC),
        .we      (we),
        .cfg_div (CFG_DIV),
        .cfg_high(CFG_HIGH),
        .tick    (TICK),
        .clk_out (CLK_OUT),
        .pend    (PEND)
    );
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, duty, reconfig timing, sync, pause, edge cases.

module tb_clk_div_bank;
    logic        CLK = 1'b0;
    logic        RST = 1'b1, EN = 1'b1, SYNC = 1'b0, CFG_WE = 1'b0;
    logic [1:0]  CFG_CH = '0;
    logic [15:0] CFG_DIV = '0, CFG_HIGH = '0;
    logic [3:0]  TICK, CLK_OUT, PEND;
    logic [2:0]  tick3, clk3, pend3;
    int errors = 0, checks = 0;

    clk_div_bank #(.N_CH(4), .WIDTH(16), .DEFAULT_DIV(2)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_DIV(CFG_DIV), .CFG_HIGH(CFG_HIGH), .TICK(TICK), .CLK_OUT(CLK_OUT), .PEND(PEND));

    // three-channel copy so that channel number 3 is out of range
    clk_div_bank #(.N_CH(3), .WIDTH(16), .DEFAULT_DIV(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_DIV(CFG_DIV), .CFG_HIGH(CFG_HIGH), .TICK(tick3), .CLK_OUT(clk3), .PEND(pend3));

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] d, input logic [15:0] h);
        CFG_WE = 1'b1; CFG_CH = ch; CFG_DIV = d; CFG_HIGH = h;
        step();
        CFG_WE = 1'b0;
    endtask

    task automatic sync_pulse();
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        RST = 1'b1; EN = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (TICK !== 4'h0) begin errors++; $display("FAIL rst_tick got=%h exp=0", TICK); end
        checks++; if (CLK_OUT !== 4'h0) begin errors++; $display("FAIL rst_clk got=%h exp=0", CLK_OUT); end
        checks++; if (PEND !== 4'h0) begin errors++; $display("FAIL rst_pend got=%h exp=0", PEND); end
        RST = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            e = (n % 2 == 0) ? 4'hF : 4'h0;
            checks++; if (TICK !== e) begin errors++; $display("FAIL dflt_tick n=%0d got=%h exp=%h", n, TICK, e); end
            checks++; if (CLK_OUT !== e) begin errors++; $display("FAIL dflt_clk n=%0d got=%h exp=%h", n, CLK_OUT, e); end
        end
        checks++; if (PEND !== 4'h0) begin errors++; $display("FAIL dflt_pend got=%h exp=0", PEND); end
    endtask

    task automatic test_divide_duty();
        int dv[4] = '{2, 5, 5, 4};
        int hi[4] = '{1, 2, 0, 7};
        int ph;
        logic [3:0] et, ec;
        EN = 1'b0;
        cfg(2'd1, 16'd5, 16'd2);
        cfg(2'd2, 16'd5, 16'd0);
        cfg(2'd3, 16'd4, 16'd7);
        checks++; if (PEND !== 4'b1110) begin errors++; $display("FAIL duty_pend got=%b exp=1110", PEND); end
        sync_pulse();
        checks++; if (TICK !== 4'h0) begin errors++; $display("FAIL duty_sync_tick got=%b exp=0000", TICK); end
        checks++; if (PEND !== 4'h0) begin errors++; $display("FAIL duty_sync_pend got=%b exp=0000", PEND); end
        checks++; if (CLK_OUT !== 4'b1011) begin errors++; $display("FAIL duty_sync_clk got=%b exp=1011", CLK_OUT); end
        EN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            et = '0; ec = '0;
            for (int c = 0; c < 4; c++) begin
                ph = k % dv[c];
                et[c] = (ph == 0);
                ec[c] = (ph < hi[c]);
            end
            checks++; if (TICK !== et) begin errors++; $display("FAIL duty_tick k=%0d got=%b exp=%b", k, TICK, et); end
            checks++; if (CLK_OUT !== ec) begin errors++; $display("FAIL duty_clk k=%0d got=%b exp=%b", k, CLK_OUT, ec); end
        end
    endtask

    task automatic test_reconfig();
        logic et, ep;
        EN = 1'b0;
        cfg(2'd0, 16'd8, 16'd4);
        sync_pulse();
        EN = 1'b1;
        step(); step();
        // ch0 cnt is now 2; write edge moves it to 3
        cfg(2'd0, 16'd3, 16'd1);
        checks++; if (PEND[0] !== 1'b1) begin errors++; $display("FAIL recfg_pend_set got=%b exp=1", PEND[0]); end
        for (int m = 1; m <= 16; m++) begin
            step();
            et = (m == 5 || m == 8 || m == 11 || m == 14);
            ep = (m < 5);
            checks++; if (TICK[0] !== et) begin errors++; $display("FAIL recfg_tick m=%0d got=%b exp=%b", m, TICK[0], et); end
            checks++; if (PEND[0] !== ep) begin errors++; $display("FAIL recfg_pend m=%0d got=%b exp=%b", m, PEND[0], ep); end
        end
        // cnt is 2 of 3: this write lands on the wrap edge and must wait a full old period
        cfg(2'd0, 16'd4, 16'd2);
        checks++; if (TICK[0] !== 1'b1) begin errors++; $display("FAIL wrapwr_tick got=%b exp=1", TICK[0]); end
        checks++; if (PEND[0] !== 1'b1) begin errors++; $display("FAIL wrapwr_pend got=%b exp=1", PEND[0]); end
        for (int m = 18; m <= 25; m++) begin
            step();
            et = (m == 20 || m == 24);
            ep = (m < 20);
            checks++; if (TICK[0] !== et) begin errors++; $display("FAIL wrapwr_tick m=%0d got=%b exp=%b", m, TICK[0], et); end
            checks++; if (PEND[0] !== ep) begin errors++; $display("FAIL wrapwr_pend m=%0d got=%b exp=%b", m, PEND[0], ep); end
        end
    endtask

    task automatic test_sync();
        logic [1:0] et;
        EN = 1'b0;
        cfg(2'd1, 16'd6, 16'd3);
        sync_pulse();
        EN = 1'b1;
        for (int i = 0; i < 7; i++) step();
        // ch0 sits at its last count here, so only SYNC stops a tick
        sync_pulse();
        checks++; if (TICK[1:0] !== 2'b00) begin errors++; $display("FAIL sync_notick got=%b exp=00", TICK[1:0]); end
        for (int k = 1; k <= 12; k++) begin
            step();
            et = {(k % 6 == 0), (k % 4 == 0)};
            checks++; if (TICK[1:0] !== et) begin errors++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, TICK[1:0], et); end
        end
    endtask

    task automatic test_pause();
        EN = 1'b0;
        cfg(2'd0, 16'd5, 16'd3);
        sync_pulse();
        EN = 1'b1;
        step(); step();
        EN = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            step();
            checks++; if (TICK[0] !== 1'b0) begin errors++; $display("FAIL pause_tick k=%0d got=%b exp=0", k, TICK[0]); end
            checks++; if (CLK_OUT[0] !== 1'b1) begin errors++; $display("FAIL pause_clk k=%0d got=%b exp=1", k, CLK_OUT[0]); end
        end
        EN = 1'b1;
        for (int k = 6; k <= 13; k++) begin
            step();
            checks++; if (TICK[0] !== (k == 8 || k == 13)) begin
                errors++; $display("FAIL pause_resume k=%0d got=%b exp=%b", k, TICK[0], (k == 8 || k == 13));
            end
        end
    endtask

    task automatic test_edges();
        logic [3:0] e;
        EN = 1'b0;
        cfg(2'd3, 16'd9, 16'd4);
        checks++; if (PEND[3] !== 1'b1) begin errors++; $display("FAIL ch3_pend got=%b exp=1", PEND[3]); end
        checks++; if (pend3 !== 3'b000) begin errors++; $display("FAIL badch_pend got=%b exp=000", pend3); end
        cfg(2'd2, 16'd1, 16'd1);
        sync_pulse();
        checks++; if (PEND !== 4'h0) begin errors++; $display("FAIL d1_pend got=%b exp=0000", PEND); end
        EN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (TICK[2] !== 1'b0 || CLK_OUT[2] !== 1'b0) begin
                errors++; $display("FAIL d1_stopped k=%0d tick=%b clk=%b exp=0,0", k, TICK[2], CLK_OUT[2]);
            end
        end
        step(); step();
        RST = 1'b1;
        step();
        checks++; if (TICK !== 4'h0) begin errors++; $display("FAIL midrst_tick got=%b exp=0000", TICK); end
        checks++; if (CLK_OUT !== 4'h0) begin errors++; $display("FAIL midrst_clk got=%b exp=0000", CLK_OUT); end
        checks++; if (PEND !== 4'h0) begin errors++; $display("FAIL midrst_pend got=%b exp=0000", PEND); end
        RST = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            e = (n % 2 == 0) ? 4'hF : 4'h0;
            checks++; if (TICK !== e) begin errors++; $display("FAIL midrst_dflt n=%0d got=%b exp=%b", n, TICK, e); end
        end
    endtask

    initial begin
        test_reset();
        test_divide_duty();
        test_reconfig();
        test_sync();
        test_pause();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
